// File: rtl/calc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_ctrl_pkg
//  Purpose  : Shared definitions for the calculator control sequencer:
//             state encoding, state width and default digit limits.
//  Ports    : none (package)
//  Options  : none here; the top honours ERROR_FLAG_EN
//  Revision : 1.0  initial release
// ============================================================================
package calc_ctrl_pkg;

    localparam int c_STATE_W    = 2;
    localparam int c_MAX_DIGITS = 4;
    localparam int c_CNT_W      = 3;

    typedef enum logic [c_STATE_W-1:0] {
        S_NUM1   = 2'd0,   // collecting first operand
        S_NUM2   = 2'd1,   // collecting second operand
        S_RESULT = 2'd2    // result valid, datapath reads/displays it
    } state_t;

endpackage : calc_ctrl_pkg
`default_nettype wire

// File: rtl/state_machine_calculator_if.sv
`default_nettype none
// ============================================================================
//  Module   : state_machine_calculator_if
//  Purpose  : Keypad-strobe / datapath-command bundle for the calculator
//             control sequencer.
//  Signals  : rec_op, rec_num   keypad decoder strobes (into sequencer)
//             guardeNum         store-digit pulse to datapath
//             leaResult         read/display-result level to datapath
//             err               rejected-key pulse (only with ERROR_FLAG_EN)
//  Modports : master = keypad/datapath side, slave = sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface state_machine_calculator_if;

    logic rec_op;
    logic rec_num;
    logic guardeNum;
    logic leaResult;
`ifdef ERROR_FLAG_EN
    logic err;
`endif

    modport master (
        output rec_op,
        output rec_num,
        input  guardeNum,
        input  leaResult
`ifdef ERROR_FLAG_EN
        ,
        input  err
`endif
    );

    modport slave (
        input  rec_op,
        input  rec_num,
        output guardeNum,
        output leaResult
`ifdef ERROR_FLAG_EN
        ,
        output err
`endif
    );

endinterface : state_machine_calculator_if
`default_nettype wire

// File: rtl/calc_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : calc_digit_counter
//  Purpose  : Saturating digit counter with clear, increment and full flag.
//  Ports    : clk, rst      clock, async active-high reset
//             i_clr         clear count (with i_inc: load 1)
//             i_inc         increment, ignored when full
//             o_count       current count
//             o_full        count == MAX_DIGITS
//  Revision : 1.0  initial release
// ============================================================================
module calc_digit_counter #(
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_full
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full = (r_count == c_MAX);

    // Clear together with increment loads 1: a digit that starts a fresh
    // calculation from the result state is itself the first digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= i_inc ? c_ONE : '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;
    assign o_full  = w_full;

endmodule : calc_digit_counter
`default_nettype wire

// File: rtl/state_machine_calculator.sv
`default_nettype none
// ============================================================================
//  Module   : state_machine_calculator
//  Purpose  : Control sequencer for the calculator datapath. Tracks operand
//             phase and digit count, issues store-digit pulses (guardeNum)
//             and holds the read-result level (leaResult). No operand data.
//  Ports    : clk   system clock (rising edge)
//             rst   async active-high reset
//             bus   state_machine_calculator_if.slave
//                   (rec_op, rec_num in; guardeNum, leaResult[, err] out)
//  Options  : ERROR_FLAG_EN - adds registered err pulse for a digit rejected
//             at the digit limit, an operator with no digits entered, or
//             simultaneous operator/digit strobes.
//  Revision : 1.0  initial release
// ============================================================================
module state_machine_calculator
    import calc_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS = c_MAX_DIGITS,
    parameter int CNT_W      = c_CNT_W
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    state_machine_calculator_if.slave   bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_guarde;
    logic             r_lea;
    logic             w_guarde_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_count;
    logic             w_cnt_full;
    logic             w_cnt_zero;

    calc_digit_counter #(
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (w_count),
        .o_full  (w_cnt_full)
    );

    assign w_cnt_zero = (w_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_NUM1;
            r_guarde <= 1'b0;
            r_lea    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_guarde <= w_guarde_nxt;
            // leaResult is simply "we will be in S_RESULT next cycle"
            r_lea    <= (w_state_nxt == S_RESULT);
        end
    end

    // Operator strobe wins over a digit strobe in the same cycle; the digit
    // is dropped.
    always_comb begin
        w_state_nxt  = r_state;
        w_guarde_nxt = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_NUM1, S_NUM2: begin
                if (bus.rec_op) begin
                    if (!w_cnt_zero) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = (r_state == S_NUM1) ? S_NUM2 : S_RESULT;
                    end
                end else if (bus.rec_num && !w_cnt_full) begin
                    w_cnt_inc    = 1'b1;
                    w_guarde_nxt = 1'b1;
                end
            end
            S_RESULT: begin
                if (bus.rec_op) begin
                    // Result chains as first operand
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_NUM2;
                end else if (bus.rec_num) begin
                    // New calculation; this digit is its first digit
                    w_cnt_clr    = 1'b1;
                    w_cnt_inc    = 1'b1;
                    w_guarde_nxt = 1'b1;
                    w_state_nxt  = S_NUM1;
                end
            end
            default: begin
                w_state_nxt = S_NUM1;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    assign bus.guardeNum = r_guarde;
    assign bus.leaResult = r_lea;

`ifdef ERROR_FLAG_EN
    logic r_err;
    logic w_err_evt;
    logic w_collecting;

    assign w_collecting = (r_state == S_NUM1) || (r_state == S_NUM2);

    always_comb begin
        w_err_evt = 1'b0;
        if (bus.rec_op && bus.rec_num) begin
            w_err_evt = 1'b1;
        end else if (w_collecting && bus.rec_op && w_cnt_zero) begin
            w_err_evt = 1'b1;
        end else if (w_collecting && bus.rec_num && w_cnt_full) begin
            w_err_evt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_evt;
        end
    end

    assign bus.err = r_err;
`endif

endmodule : state_machine_calculator
`default_nettype wire

// File: tb/tb_state_machine_calculator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_state_machine_calculator
//  Purpose  : Self-checking bench for state_machine_calculator: table of
//             directed vectors, hand-written corner sequences and random
//             strobes checked against a phase/digit-count reference model.
//  Options  : ERROR_FLAG_EN also checks the err pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_state_machine_calculator;
    import calc_ctrl_pkg::*;

    localparam int c_MAX = c_MAX_DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    state_machine_calculator_if bus ();

    state_machine_calculator #(
        .MAX_DIGITS (c_MAX_DIGITS),
        .CNT_W      (c_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = first operand, 1 = second, 2 = result
    int m_phase;
    int m_digits;
    bit m_g;
    bit m_l;
    bit m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_digits = 0;
        m_g = 0; m_l = 0; m_e = 0;
    endtask

    task automatic model_step(input bit op, input bit num);
        m_g = 0;
        m_e = 0;
        if (m_phase == 2) begin
            if (op) begin
                m_phase  = 1;
                m_digits = 0;
                m_e      = num;
            end else if (num) begin
                m_phase  = 0;
                m_digits = 1;
                m_g      = 1;
            end
        end else begin
            if (op) begin
                m_e = num || (m_digits == 0);
                if (m_digits > 0) begin
                    m_phase  = m_phase + 1;
                    m_digits = 0;
                end
            end else if (num) begin
                if (m_digits < c_MAX) begin
                    m_digits = m_digits + 1;
                    m_g      = 1;
                end else begin
                    m_e = 1;
                end
            end
        end
        m_l = (m_phase == 2);
    endtask

    // One clock with the given strobes; outputs compared 1 time unit after the edge
    task automatic step(input bit op, input bit num);
        bus.rec_op  = op;
        bus.rec_num = num;
        @(posedge clk);
        #1;
        model_step(op, num);
        check("guardeNum", 32'(bus.guardeNum), 32'(m_g));
        check("leaResult", 32'(bus.leaResult), 32'(m_l));
        check("state", 32'(dut.r_state), 32'(m_phase));
        check("count", 32'(dut.w_count), 32'(m_digits));
`ifdef ERROR_FLAG_EN
        check("err", 32'(bus.err), 32'(m_e));
`endif
        bus.rec_op  = 1'b0;
        bus.rec_num = 1'b0;
    endtask

    task automatic do_reset();
        bus.rec_op  = 1'b0;
        bus.rec_num = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit op;
        bit num;
        bit g;
        bit l;
        int st;
        bit e;
    } vec_t;

    vec_t tbl[13];

    initial begin : main
        int g_cnt;
        int g_run;
        int g_max_run;
        int e_cnt;

        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0}; // digit 1
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0}; // digit 2
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0}; // op -> NUM2
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0}; // digit
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0}; // op -> RESULT
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0}; // idle, result held
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0}; // chain -> NUM2
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1}; // empty op ignored
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0}; // digit
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0}; // op -> RESULT
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0}; // new calc, count 1
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1}; // both: op wins
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0}; // idle

        bus.rec_op  = 1'b0;
        bus.rec_num = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Mid-cycle reset aborts a pending guardeNum immediately
        bus.rec_num = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_guardeNum", 32'(bus.guardeNum), 32'd0);
        check("rst_async_leaResult", 32'(bus.leaResult), 32'd0);
        check("rst_async_state", 32'(dut.r_state), 32'(S_NUM1));
        check("rst_async_count", 32'(dut.w_count), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_guardeNum", 32'(bus.guardeNum), 32'd0);
        bus.rec_num = 1'b0;
        rst = 1'b0;
        model_reset();

        // Empty operator right after reset
        step(1'b1, 1'b0);
        check("empty_op_state", 32'(dut.r_state), 32'(S_NUM1));

        // Directed table: full calculation, chaining, simultaneous strobes
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].op, tbl[i].num);
            check($sformatf("tbl%0d_guardeNum", i), 32'(bus.guardeNum), 32'(tbl[i].g));
            check($sformatf("tbl%0d_leaResult", i), 32'(bus.leaResult), 32'(tbl[i].l));
            check($sformatf("tbl%0d_state", i), 32'(dut.r_state), 32'(tbl[i].st));
`ifdef ERROR_FLAG_EN
            check($sformatf("tbl%0d_err", i), 32'(bus.err), 32'(tbl[i].e));
`endif
        end

        // Digit burst of 3 then operator: exactly 3 consecutive guardeNum cycles
        do_reset();
        g_cnt = 0; g_run = 0; g_max_run = 0;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, i < 3);
            if (bus.guardeNum) begin
                g_cnt++;
                g_run++;
                if (g_run > g_max_run) g_max_run = g_run;
            end else begin
                g_run = 0;
            end
        end
        check("burst_guarde_count", 32'(g_cnt), 32'd3);
        check("burst_guarde_run", 32'(g_max_run), 32'd3);
        check("burst_state", 32'(dut.r_state), 32'(S_NUM2));
        check("burst_leaResult", 32'(bus.leaResult), 32'd0);

        // Saturation: six digits, only MAX_DIGITS accepted
        do_reset();
        g_cnt = 0; e_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            if (bus.guardeNum) g_cnt++;
`ifdef ERROR_FLAG_EN
            if (bus.err) e_cnt++;
`endif
        end
        step(1'b0, 1'b0);
        check("sat_guarde_count", 32'(g_cnt), 32'(c_MAX));
        check("sat_count_hold", 32'(dut.w_count), 32'(c_MAX));
`ifdef ERROR_FLAG_EN
        check("sat_err_count", 32'(e_cnt), 32'd2);
`endif

        // Simultaneous strobes with count = 2 in S_NUM1
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("simul_state", 32'(dut.r_state), 32'(S_NUM2));
        check("simul_guardeNum", 32'(bus.guardeNum), 32'd0);

        // Randomised strobes against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_state_machine_calculator
`default_nettype wire
